// File: rtl/clock_gate_ctrl_pkg.sv
// Shared encodings for the CPU clock gate controller.
// Mode inputs and FSM states.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_DIV  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STEPPING = 2'b10,
    ST_DIVIDING = 2'b11
  } state_e;

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Control and status bundle of the clock gate controller.
// master drives mode/step inputs, slave is the controller.
interface clock_gate_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8,
  parameter int CYC_W = 32
);
  logic [1:0]       mode;
  logic             step_req;
  logic [CNT_W-1:0] step_count;
  logic [DIV_W-1:0] div_ratio;
  logic             clk_en;
  logic             clk_out;
  logic             busy;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output mode, step_req, step_count, div_ratio,
    input  clk_en, clk_out, busy, cycle_count
  );

  modport slave (
    input  mode, step_req, step_count, div_ratio,
    output clk_en, clk_out, busy, cycle_count
  );
endinterface

// File: rtl/clock_gate_ctrl_sync_edge_detect.sv
// Synchronizer for an async level plus a one-cycle
// rising-edge pulse in the clk domain.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);
  logic [STAGES-1:0] chain;
  logic              prev;

  // shift the async level through the chain, keep last value
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign pulse = chain[STAGES-1] & ~prev;
endmodule

// File: rtl/clock_gate_ctrl.sv
// Glitch-free gated clock / enable generator for the CPU:
// halt, run, step bursts and divide-by-N.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CYC_W       = 32
) (
  input  logic clk_in,
  input  logic reset,
  clock_gate_ctrl_if.slave bus
);
  state_e           state;
  state_e           state_nx;
  logic             step_pulse;
  logic             en_d;
  logic             en_q;
  logic             en_n;
  logic             busy_d;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] step_n;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] ratio_n;
  logic             div_wrap;
  logic [CYC_W-1:0] cyc_q;

  sync_edge_detect #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk_in),
    .reset   (reset),
    .async_in(bus.step_req),
    .pulse   (step_pulse)
  );

  assign step_n   = (bus.step_count == '0) ?
                    CNT_W'(1) : bus.step_count;
  assign ratio_n  = (bus.div_ratio == '0) ?
                    DIV_W'(1) : bus.div_ratio;
  assign div_wrap = (div_cnt == div_r - DIV_W'(1));

  // state register
  always_ff @(posedge clk_in) begin
    if (reset) state <= ST_HALTED;
    else       state <= state_nx;
  end

  // next-state logic; every mode change goes via HALTED
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_HALTED: begin
        if (bus.mode == MODE_RUN)
          state_nx = ST_RUNNING;
        else if (bus.mode == MODE_DIV)
          state_nx = ST_DIVIDING;
        else if (bus.mode == MODE_STEP && step_pulse)
          state_nx = ST_STEPPING;
      end
      ST_RUNNING: begin
        if (bus.mode != MODE_RUN)
          state_nx = ST_HALTED;
      end
      ST_STEPPING: begin
        if (bus.mode != MODE_STEP ||
            remaining == CNT_W'(1))
          state_nx = ST_HALTED;
      end
      ST_DIVIDING: begin
        if (bus.mode != MODE_DIV)
          state_nx = ST_HALTED;
      end
      default: state_nx = ST_HALTED;
    endcase
  end

  // enable/busy decode; an aborted step gets no more enables
  always_comb begin
    en_d   = 1'b0;
    busy_d = 1'b0;
    unique case (state)
      ST_HALTED:   en_d = 1'b0;
      ST_RUNNING:  en_d = 1'b1;
      ST_STEPPING: begin
        en_d   = (bus.mode == MODE_STEP);
        busy_d = 1'b1;
      end
      ST_DIVIDING: en_d = (div_cnt == '0);
      default:     en_d = 1'b0;
    endcase
  end

  // burst length and divider counters
  always_ff @(posedge clk_in) begin
    if (reset) begin
      remaining <= '0;
      div_cnt   <= '0;
      div_r     <= DIV_W'(1);
    end else begin
      if (state == ST_HALTED &&
          state_nx == ST_STEPPING)
        remaining <= step_n;
      else if (state == ST_STEPPING)
        remaining <= remaining - CNT_W'(1);

      if (state == ST_DIVIDING &&
          state_nx == ST_DIVIDING) begin
        if (div_wrap) begin
          div_cnt <= '0;
          div_r   <= ratio_n;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
        div_r   <= ratio_n;
      end
    end
  end

  // registered enable and issued-cycle counter
  always_ff @(posedge clk_in) begin
    if (reset) begin
      en_q  <= 1'b0;
      cyc_q <= '0;
    end else begin
      en_q  <= en_d;
      cyc_q <= cyc_q + {{(CYC_W-1){1'b0}}, en_q};
    end
  end

  // latch enable while clk_in is low so clk_out cannot glitch
  always_ff @(negedge clk_in) begin
    en_n <= en_q;
  end

  assign bus.clk_en      = en_q;
  assign bus.clk_out     = clk_in & en_n;
  assign bus.busy        = busy_d;
  assign bus.cycle_count = cyc_q;
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomized self-checking bench for clock_gate_ctrl.
// Counts clk_out pulses against a schedule model.
module tb_clock_gate_ctrl;
  import clock_gate_pkg::*;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   pulse_cnt;
  int   busy_cnt;
  int   en_cnt;
  logic [31:0] exp_cyc;
  realtime t_rise;

  clock_gate_ctrl_if #(
    .CNT_W(16), .DIV_W(8), .CYC_W(32)
  ) bus ();

  clock_gate_ctrl #(
    .CNT_W(16), .DIV_W(8),
    .SYNC_STAGES(2), .CYC_W(32)
  ) dut (
    .clk_in(clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse / activity observers
  always @(posedge bus.clk_out) begin
    pulse_cnt++;
    t_rise = $realtime;
  end

  always @(negedge bus.clk_out) begin
    n_assert++;
    if ($realtime - t_rise < 5.0) begin
      n_fail++;
      $display("FAIL glitch: clk_out high %0t, need >= 5",
               $realtime - t_rise);
    end
  end

  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.clk_en) en_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.mode       = MODE_HALT;
    bus.step_req   = 1'b0;
    bus.step_count = '0;
    bus.div_ratio  = '0;
    cycles(3);
    n_assert++;
    if (bus.clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clk_en: got %b want 0", bus.clk_en);
    end
    n_assert++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_assert++;
    if (bus.cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cyc: got %0d want 0",
               bus.cycle_count);
    end
    @(posedge clk);
    #2;
    n_assert++;
    if (bus.clk_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clk_out: got %b want 0",
               bus.clk_out);
    end
    @(negedge clk);
    reset   = 1'b0;
    exp_cyc = 32'd0;
    cycles(2);
  endtask

  task automatic test_run(input int m);
    int base;
    base = pulse_cnt;
    bus.mode = MODE_RUN;
    @(posedge clk);
    #1;
    n_assert++;
    if (bus.clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL run_en_p1: got %b want 0", bus.clk_en);
    end
    @(posedge clk);
    #1;
    n_assert++;
    if (bus.clk_en !== 1'b1) begin
      n_fail++;
      $display("FAIL run_en_p2: got %b want 1", bus.clk_en);
    end
    repeat (m - 2) @(posedge clk);
    @(negedge clk);
    bus.mode = MODE_HALT;
    cycles(4);
    exp_cyc = exp_cyc + 32'(m);
    n_assert++;
    if (pulse_cnt - base !== m) begin
      n_fail++;
      $display("FAIL run_pulses: got %0d want %0d",
               pulse_cnt - base, m);
    end
    n_assert++;
    if (bus.cycle_count !== exp_cyc) begin
      n_fail++;
      $display("FAIL run_cyc: got %0d want %0d",
               bus.cycle_count, exp_cyc);
    end
  endtask

  task automatic test_step(input int n, input bit dbl);
    int base;
    int bbase;
    int want;
    want = (n == 0) ? 1 : n;
    bus.mode       = MODE_STEP;
    bus.step_count = 16'(n);
    cycles(2);
    base  = pulse_cnt;
    bbase = busy_cnt;
    bus.step_req = 1'b1;
    if (dbl) begin
      cycles(2);
      bus.step_req = 1'b0;
      cycles(2);
      bus.step_req = 1'b1;
    end
    cycles(want + 12);
    bus.step_req = 1'b0;
    cycles(3);
    bus.mode = MODE_HALT;
    cycles(3);
    exp_cyc = exp_cyc + 32'(want);
    n_assert++;
    if (pulse_cnt - base !== want) begin
      n_fail++;
      $display("FAIL step_pulses n=%0d: got %0d want %0d",
               n, pulse_cnt - base, want);
    end
    n_assert++;
    if (busy_cnt - bbase !== want) begin
      n_fail++;
      $display("FAIL step_busy n=%0d: got %0d want %0d",
               n, busy_cnt - bbase, want);
    end
    n_assert++;
    if (bus.cycle_count !== exp_cyc) begin
      n_fail++;
      $display("FAIL step_cyc: got %0d want %0d",
               bus.cycle_count, exp_cyc);
    end
  endtask

  task automatic test_div(input int m, input int r);
    int  base;
    int  rr;
    int  want;
    int  bad;
    bit  en_obs [64];
    bit  en_exp;
    rr   = (r == 0) ? 1 : r;
    want = (m + rr - 1) / rr;
    base = pulse_cnt;
    bad  = 0;
    bus.div_ratio = 8'(r);
    bus.mode      = MODE_DIV;
    for (int i = 0; i < m + 6; i++) begin
      @(negedge clk);
      en_obs[i] = bus.clk_en;
      if (i == m - 1) bus.mode = MODE_HALT;
    end
    for (int i = 0; i < m + 6; i++) begin
      en_exp = (i >= 1) && (i <= m) && ((i - 1) % rr == 0);
      if (en_obs[i] != en_exp) bad++;
    end
    exp_cyc = exp_cyc + 32'(want);
    n_assert++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL div_pattern r=%0d: %0d wrong slots want 0",
               r, bad);
    end
    n_assert++;
    if (pulse_cnt - base !== want) begin
      n_fail++;
      $display("FAIL div_pulses r=%0d m=%0d: got %0d want %0d",
               r, m, pulse_cnt - base, want);
    end
    n_assert++;
    if (bus.cycle_count !== exp_cyc) begin
      n_fail++;
      $display("FAIL div_cyc: got %0d want %0d",
               bus.cycle_count, exp_cyc);
    end
  endtask

  task automatic test_abort();
    int  base;
    int  ebase;
    int  got;
    bit  hit;
    bus.mode       = MODE_STEP;
    bus.step_count = 16'd100;
    cycles(2);
    base  = pulse_cnt;
    ebase = en_cnt;
    hit   = 1'b0;
    bus.step_req = 1'b1;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (pulse_cnt - base >= 10) hit = 1'b1;
    end
    bus.mode = MODE_HALT;
    n_assert++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_timeout: got %0d pulses want 10",
               pulse_cnt - base);
    end
    cycles(10);
    bus.step_req = 1'b0;
    cycles(2);
    got = pulse_cnt - base;
    n_assert++;
    if (got < 10 || got > 11) begin
      n_fail++;
      $display("FAIL abort_pulses: got %0d want 10..11", got);
    end
    n_assert++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %b want 0", bus.busy);
    end
    n_assert++;
    if (en_cnt - ebase !== got) begin
      n_fail++;
      $display("FAIL abort_en_vs_pulse: got %0d want %0d",
               en_cnt - ebase, got);
    end
    exp_cyc = exp_cyc + 32'(got);
    n_assert++;
    if (bus.cycle_count !== exp_cyc) begin
      n_fail++;
      $display("FAIL abort_cyc: got %0d want %0d",
               bus.cycle_count, exp_cyc);
    end
  endtask

  task automatic test_reset_mid_run();
    int base;
    bus.mode = MODE_RUN;
    cycles(6);
    reset    = 1'b1;
    bus.mode = MODE_HALT;
    @(posedge clk);
    @(negedge clk);
    base = pulse_cnt;
    n_assert++;
    if (bus.cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_cyc: got %0d want 0",
               bus.cycle_count);
    end
    cycles(2);
    reset = 1'b0;
    cycles(4);
    exp_cyc = 32'd0;
    n_assert++;
    if (pulse_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_pulses: got %0d want 0",
               pulse_cnt - base);
    end
    n_assert++;
    if (bus.clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_en: got %b want 0", bus.clk_en);
    end
    n_assert++;
    if (bus.cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_cyc_after: got %0d want 0",
               bus.cycle_count);
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    busy_cnt  = 0;
    en_cnt    = 0;
    exp_cyc   = 32'd0;
    t_rise    = 0;
    test_reset();
    test_run(10);
    test_step(3, 1'b0);
    test_step(0, 1'b0);
    test_step(5, 1'b1);
    test_div(20, 4);
    test_div(12, 0);
    for (int k = 0; k < 3; k++) begin
      test_run(int'($urandom_range(2, 12)));
      test_step(int'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)));
      test_div(int'($urandom_range(5, 25)),
               int'($urandom_range(0, 6)));
    end
    test_abort();
    test_reset_mid_run();
    test_run(4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
